// File: rtl/blink_mon_pkg.sv
// Shared types and constants for the blink_monitor blink-line checker.
// Optional statistics outputs are enabled with BLINK_MON_STATS_EN.
package blink_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } state_e;

  localparam int MISMATCH_CNT_W = 8;
  localparam int RUN_W          = 4;

  localparam logic [MISMATCH_CNT_W-1:0] MISMATCH_CNT_MAX = 8'hFF;
  localparam logic [MISMATCH_CNT_W-1:0] MISMATCH_CNT_ONE = 8'h01;

  function automatic logic [MISMATCH_CNT_W-1:0] sat_inc_mcnt(input logic [MISMATCH_CNT_W-1:0] v);
    if (v == MISMATCH_CNT_MAX) begin
      return v;
    end else begin
      return v + MISMATCH_CNT_ONE;
    end
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the blink line; prev is cleared by reset and by clear.
module rise_detect
  import blink_mon_pkg::*;
(
  input  logic clk_edge,
  input  logic rstbtn,
  input  logic clear,
  input  logic d,
  output logic rise
);

  logic prev_q;

  // previous sample of the line
  always_ff @(posedge clk_edge or posedge rstbtn) begin
    if (rstbtn) begin
      prev_q <= 1'b0;
    end else if (clear) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/blink_monitor.sv
// Blink-line interval checker: measures rise-to-rise intervals, locks, counts mismatches, times out.
// Define BLINK_MON_STATS_EN to add min_period/max_period outputs.
module blink_monitor
  import blink_mon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 3,
  parameter int TIMEOUT    = 200
) (
  input  logic                      clk_edge,
  input  logic                      rstbtn,
  input  logic                      blink_in,
  input  logic                      clear,
  input  logic [CNT_W-1:0]          expected_interval,
  output logic [CNT_W-1:0]          period_out,
  output logic                      period_valid,
  output logic                      locked,
  output logic                      mismatch,
  output logic                      timeout,
  output logic [MISMATCH_CNT_W-1:0] mismatch_count
`ifdef BLINK_MON_STATS_EN
  ,
  output logic [CNT_W-1:0]          min_period,
  output logic [CNT_W-1:0]          max_period
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [RUN_W-1:0] LOCK_V    = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [RUN_W-1:0]            run_q, run_d;
  logic [CNT_W-1:0]            period_q, period_d;
  logic                        pvalid_q, pvalid_d;
  logic                        mism_q, mism_d;
  logic                        tout_q, tout_d;
  logic                        locked_q, locked_d;
  logic [MISMATCH_CNT_W-1:0]   mcnt_q, mcnt_d;

  logic                        rise_s;
  logic [CNT_W:0]              meas_s;
  logic                        match_s;
  logic                        report_s;
  logic                        miss_s;
  logic                        tout_set_s;
  logic                        tout_clr_s;

  rise_detect u_rise (
    .clk_edge (clk_edge),
    .rstbtn   (rstbtn),
    .clear    (clear),
    .d        (blink_in),
    .rise     (rise_s)
  );

  // widened so a zero expectation can never match
  assign meas_s  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign match_s = (meas_s == {1'b0, expected_interval});

  // saturating interval counter
  always_comb begin
    cnt_d = cnt_q;
    if (rise_s) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // next state, lock run and event decode
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    report_s   = 1'b0;
    miss_s     = 1'b0;
    tout_set_s = 1'b0;
    tout_clr_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d    = ARMED;
          tout_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED, MEASURE, LOCKED: begin
        if (rise_s) begin
          report_s = 1'b1;
          if (!match_s) begin
            miss_s  = 1'b1;
            run_d   = '0;
            state_d = MEASURE;
          end else if (state_q == LOCKED) begin
            state_d = LOCKED;
          end else if ((run_q + RUN_ONE) == LOCK_V) begin
            run_d   = run_q + RUN_ONE;
            state_d = LOCKED;
          end else begin
            run_d   = run_q + RUN_ONE;
            state_d = MEASURE;
          end
        end else if (cnt_q == TIMEOUT_V) begin
          state_d    = IDLE;
          run_d      = '0;
          tout_set_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = '0;
      end
    endcase
  end

  // registered output next values
  always_comb begin
    period_d = report_s ? meas_s[CNT_W-1:0] : period_q;
    pvalid_d = report_s;
    mism_d   = miss_s;
    locked_d = (state_d == LOCKED);
    if (miss_s) begin
      mcnt_d = sat_inc_mcnt(mcnt_q);
    end else begin
      mcnt_d = mcnt_q;
    end
    if (tout_set_s) begin
      tout_d = 1'b1;
    end else if (tout_clr_s) begin
      tout_d = 1'b0;
    end else begin
      tout_d = tout_q;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk_edge or posedge rstbtn) begin
    if (rstbtn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      run_q    <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
      mism_q   <= 1'b0;
      tout_q   <= 1'b0;
      locked_q <= 1'b0;
      mcnt_q   <= '0;
    end else if (clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      run_q    <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
      mism_q   <= 1'b0;
      tout_q   <= 1'b0;
      locked_q <= 1'b0;
      mcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      period_q <= period_d;
      pvalid_q <= pvalid_d;
      mism_q   <= mism_d;
      tout_q   <= tout_d;
      locked_q <= locked_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign period_out     = period_q;
  assign period_valid   = pvalid_q;
  assign mismatch       = mism_q;
  assign timeout        = tout_q;
  assign locked         = locked_q;
  assign mismatch_count = mcnt_q;

`ifdef BLINK_MON_STATS_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;

  // extremes over reported intervals
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (report_s && (meas_s[CNT_W-1:0] < min_q)) begin
      min_d = meas_s[CNT_W-1:0];
    end else begin
      min_d = min_q;
    end
    if (report_s && (meas_s[CNT_W-1:0] > max_q)) begin
      max_d = meas_s[CNT_W-1:0];
    end else begin
      max_d = max_q;
    end
  end

  // statistics registers
  always_ff @(posedge clk_edge or posedge rstbtn) begin
    if (rstbtn) begin
      min_q <= CNT_MAX;
      max_q <= '0;
    end else if (clear) begin
      min_q <= CNT_MAX;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_period = min_q;
  assign max_period = max_q;
`endif

endmodule

// File: tb/tb_blink_monitor.sv
// Directed bench for blink_monitor with an interval-based reference model checked every cycle.
module tb_blink_monitor;

  localparam int CNT_W      = 8;
  localparam int LOCK_COUNT = 3;
  localparam int TIMEOUT    = 200;

  logic             clk_edge = 1'b0;
  logic             rstbtn   = 1'b1;
  logic             blink_in = 1'b0;
  logic             clear    = 1'b0;
  logic [CNT_W-1:0] expected_interval = 8'd10;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             mismatch;
  logic             timeout;
  logic [7:0]       mismatch_count;
`ifdef BLINK_MON_STATS_EN
  logic [CNT_W-1:0] min_period;
  logic [CNT_W-1:0] max_period;
`endif

  int n_chk = 0;
  int n_err = 0;

  blink_monitor #(.CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)) dut (
    .clk_edge          (clk_edge),
    .rstbtn            (rstbtn),
    .blink_in          (blink_in),
    .clear             (clear),
    .expected_interval (expected_interval),
    .period_out        (period_out),
    .period_valid      (period_valid),
    .locked            (locked),
    .mismatch          (mismatch),
    .timeout           (timeout),
    .mismatch_count    (mismatch_count)
`ifdef BLINK_MON_STATS_EN
    ,
    .min_period        (min_period),
    .max_period        (max_period)
`endif
  );

  always #5 clk_edge = ~clk_edge;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the cycle number of the last reference rise.
  int m_cyc, m_last, m_run, m_mcnt, m_period, m_min, m_max;
  bit m_prev, m_ref, m_locked, m_tmo, m_pv, m_mis;

  task automatic m_reset();
    m_prev = 1'b0; m_ref = 1'b0; m_locked = 1'b0; m_tmo = 1'b0;
    m_pv = 1'b0; m_mis = 1'b0; m_run = 0; m_mcnt = 0; m_period = 0;
    m_min = 255; m_max = 0; m_last = m_cyc;
  endtask

  task automatic m_step();
    int interval;
    bit r;
    m_cyc++;
    if (clear) begin
      m_reset();
    end else begin
      r = blink_in && !m_prev;
      m_prev = blink_in;
      m_pv = 1'b0;
      m_mis = 1'b0;
      if (r) begin
        if (!m_ref) begin
          m_ref = 1'b1;
          m_tmo = 1'b0;
        end else begin
          interval = m_cyc - m_last;
          m_period = interval;
          m_pv = 1'b1;
          if (interval < m_min) m_min = interval;
          if (interval > m_max) m_max = interval;
          if (interval == int'(expected_interval)) begin
            if (!m_locked) begin
              m_run++;
              if (m_run == LOCK_COUNT) m_locked = 1'b1;
            end
          end else begin
            m_mis = 1'b1;
            if (m_mcnt < 255) m_mcnt++;
            m_run = 0;
            m_locked = 1'b0;
          end
        end
        m_last = m_cyc;
      end else if (m_ref && (m_cyc - m_last == TIMEOUT + 1)) begin
        m_ref = 1'b0;
        m_tmo = 1'b1;
        m_run = 0;
        m_locked = 1'b0;
      end
    end
  endtask

  initial begin
    m_cyc = 0;
    m_reset();
    forever begin
      @(posedge clk_edge or posedge rstbtn);
      if (rstbtn) m_reset();
      else m_step();
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk_edge);
      if (!rstbtn) begin
        chk("cmp_period_out", period_out, m_period);
        chk("cmp_period_valid", period_valid, m_pv);
        chk("cmp_locked", locked, m_locked);
        chk("cmp_mismatch", mismatch, m_mis);
        chk("cmp_timeout", timeout, m_tmo);
        chk("cmp_mismatch_count", mismatch_count, m_mcnt);
`ifdef BLINK_MON_STATS_EN
        chk("cmp_min_period", min_period, m_min);
        chk("cmp_max_period", max_period, m_max);
`endif
      end
    end
  end

  task automatic pulse(input int gap);
    blink_in = 1'b1;
    @(negedge clk_edge);
    blink_in = 1'b0;
    repeat (gap - 1) @(negedge clk_edge);
  endtask

  task automatic pin_rise(input int gap, input string tag, input int e_period,
                          input int e_locked, input int e_mis, input int e_mcnt);
    blink_in = 1'b1;
    @(negedge clk_edge);
    chk({tag, "_period"}, period_out, e_period);
    chk({tag, "_valid"}, period_valid, 1);
    chk({tag, "_locked"}, locked, e_locked);
    chk({tag, "_mismatch"}, mismatch, e_mis);
    chk({tag, "_mcount"}, mismatch_count, e_mcnt);
    blink_in = 1'b0;
    repeat (gap - 1) @(negedge clk_edge);
  endtask

  initial begin
    repeat (2) @(negedge clk_edge);
    chk("reset_period", period_out, 0);
    chk("reset_locked", locked, 0);
    chk("reset_mcount", mismatch_count, 0);
    rstbtn = 1'b0;
    @(negedge clk_edge);

    // lock on a steady 10-cycle blink, lost on a late pulse, regained after three matches
    pulse(10);
    pulse(10);
    pulse(10);
    pin_rise(10, "t1_lock", 10, 1, 0, 0);
    pulse(10);
    pulse(12);
    pin_rise(10, "t2_late", 12, 0, 1, 1);
    pulse(10);
    pulse(10);
    pin_rise(10, "t2_relock", 10, 1, 0, 1);

    // stalled line after lock
    blink_in = 1'b1;
    @(negedge clk_edge);
    blink_in = 1'b0;
    repeat (TIMEOUT) @(negedge clk_edge);
    chk("t3_tout_early", timeout, 0);
    chk("t3_locked_before", locked, 1);
    @(negedge clk_edge);
    chk("t3_tout_set", timeout, 1);
    chk("t3_locked_drop", locked, 0);
    blink_in = 1'b1;
    @(negedge clk_edge);
    chk("t3_tout_clr", timeout, 0);
    chk("t3_no_valid", period_valid, 0);
    blink_in = 1'b0;
    repeat (9) @(negedge clk_edge);
    pin_rise(10, "t3_rearm", 10, 0, 0, 1);

    // asynchronous reset between clock edges
    repeat (3) @(negedge clk_edge);
    #2 rstbtn = 1'b1;
    #1;
    chk("t4_rst_period", period_out, 0);
    chk("t4_rst_mcount", mismatch_count, 0);
    chk("t4_rst_valid", period_valid, 0);
    @(negedge clk_edge);
    rstbtn = 1'b0;
    @(negedge clk_edge);

    // clear with a coincident rise: the rise must not arm the monitor
    pulse(6);
    blink_in = 1'b1;
    clear = 1'b1;
    @(negedge clk_edge);
    clear = 1'b0;
    blink_in = 1'b0;
    chk("t4_clr_valid", period_valid, 0);
    chk("t4_clr_period", period_out, 0);
    repeat (4) @(negedge clk_edge);
    blink_in = 1'b1;
    @(negedge clk_edge);
    chk("t4_clr_idle", period_valid, 0);
    blink_in = 1'b0;
    repeat (4) @(negedge clk_edge);

    // expected=0 never matches; count saturates; held-high line gives one rise
    expected_interval = 8'd0;
    for (int i = 0; i < 260; i++) pulse(5);
    blink_in = 1'b1;
    repeat (30) @(negedge clk_edge);
    blink_in = 1'b0;
    repeat (5) @(negedge clk_edge);
    pin_rise(5, "t5_held", 35, 0, 1, 255);

`ifdef BLINK_MON_STATS_EN
    expected_interval = 8'd7;
    clear = 1'b1;
    @(negedge clk_edge);
    clear = 1'b0;
    pulse(5);
    pulse(9);
    pulse(7);
    blink_in = 1'b1;
    @(negedge clk_edge);
    blink_in = 1'b0;
    chk("t6_min", min_period, 5);
    chk("t6_max", max_period, 9);
    clear = 1'b1;
    @(negedge clk_edge);
    clear = 1'b0;
    chk("t6_clr_min", min_period, 255);
    chk("t6_clr_max", max_period, 0);
`endif

    repeat (3) @(negedge clk_edge);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
